// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Purpose:
//   Debounces a raw, asynchronous pushbutton pin. The pin first passes through
//   a SYNC_STAGES-deep synchronizer. A four-state FSM then accepts a new level
//   only after CNT_MAX consecutive synchronized samples agree on it. The block
//   also produces one-cycle strobes on each accepted edge.
//
// Parameters:
//   CNT_MAX     - consecutive stable samples needed to accept a level change
//                 (minimum 2; the default 1000000 gives 10 ms at 100 MHz)
//   SYNC_STAGES - synchronizer depth (minimum 2)
//
// Ports:
//   clk        in   system clock; every flop is rising-edge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   raw, bouncing pushbutton pin
//   btn_level  out  debounced level (registered)
//   rise_pulse out  one-cycle strobe in the first cycle btn_level reads 1
//   fall_pulse out  one-cycle strobe in the first cycle btn_level reads 0
//   press_cnt  out  [7:0] accepted-press counter, wraps 255->0
//                   (present only when BTN_PRESS_CNT_EN is defined)
//
// Optional feature macro: BTN_PRESS_CNT_EN
//
// Debug visibility: the FSM state and qualification counter are held together
// in the packed struct fsm_q (fields state and cnt).
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int CNT_MAX     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       rise_pulse,
`ifdef BTN_PRESS_CNT_EN
  output logic       fall_pulse,
  output logic [7:0] press_cnt
`else
  output logic       fall_pulse
`endif
);

  // For CNT_MAX >= 2, $clog2(CNT_MAX) bits always hold CNT_MAX-1.
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  typedef struct packed {
    state_t        state;
    logic [CW-1:0] cnt;
  } fsm_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: the only logic that samples btn_in.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Qualification FSM
  // ---------------------------------------------------------------------------
  fsm_t fsm_q;
  fsm_t fsm_d;
  logic btn_level_q;
  logic btn_level_d;
  logic rise_pulse_q;
  logic rise_pulse_d;
  logic fall_pulse_q;
  logic fall_pulse_d;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q.state)
      STABLE_LO: begin
        fsm_d.cnt = '0;
        if (s) begin
          fsm_d.state = WAIT_HI;
          fsm_d.cnt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          // Bounce back low before qualifying: abort silently.
          fsm_d.state = STABLE_LO;
          fsm_d.cnt   = '0;
        end else if (fsm_q.cnt == CNT_LAST) begin
          fsm_d.state = STABLE_HI;
          fsm_d.cnt   = '0;
        end else begin
          fsm_d.cnt = fsm_q.cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        fsm_d.cnt = '0;
        if (!s) begin
          fsm_d.state = WAIT_LO;
          fsm_d.cnt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          fsm_d.state = STABLE_HI;
          fsm_d.cnt   = '0;
        end else if (fsm_q.cnt == CNT_LAST) begin
          fsm_d.state = STABLE_LO;
          fsm_d.cnt   = '0;
        end else begin
          fsm_d.cnt = fsm_q.cnt + CNT_ONE;
        end
      end
      default: begin
        fsm_d.state = STABLE_LO;
        fsm_d.cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that btn_level and the matching
  // strobe update on the same edge as the accepting state transition.
  always_comb begin
    btn_level_d  = (fsm_d.state == STABLE_HI) || (fsm_d.state == WAIT_LO);
    rise_pulse_d = btn_level_d & ~btn_level_q;
    fall_pulse_d = ~btn_level_d & btn_level_q;
  end

`ifdef BTN_PRESS_CNT_EN
  // ---------------------------------------------------------------------------
  // Press counter: bumps in the cycle after each rise strobe, free-wrapping.
  // ---------------------------------------------------------------------------
  logic [7:0] press_cnt_q;
  logic [7:0] press_cnt_d;

  always_comb begin
    press_cnt_d = press_cnt_q + {7'd0, rise_pulse_q};
  end

  assign press_cnt = press_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      fsm_q.state  <= STABLE_LO;
      fsm_q.cnt    <= '0;
      btn_level_q  <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
`ifdef BTN_PRESS_CNT_EN
      press_cnt_q  <= 8'd0;
`endif
    end else begin
      sync_q       <= sync_d;
      fsm_q        <= fsm_d;
      btn_level_q  <= btn_level_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
`ifdef BTN_PRESS_CNT_EN
      press_cnt_q  <= press_cnt_d;
`endif
    end
  end

  assign btn_level  = btn_level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed testbench for btn_debounce with CNT_MAX=4, SYNC_STAGES=2, 10 ns
// clock. Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// each rising edge. "Edge k" below is the k-th rising edge after the input
// change, so a clean level change is expected at edge SYNC_STAGES+CNT_MAX = 6.
// Define BTN_PRESS_CNT_EN for both files to exercise the press counter.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int CNT_MAX     = 4;
  localparam int SYNC_STAGES = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
`ifdef BTN_PRESS_CNT_EN
  logic [7:0] press_cnt;
`endif

  always #5 clk = ~clk;

  btn_debounce #(
    .CNT_MAX     (CNT_MAX),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .rise_pulse (rise_pulse),
`ifdef BTN_PRESS_CNT_EN
    .fall_pulse (fall_pulse),
    .press_cnt  (press_cnt)
`else
    .fall_pulse (fall_pulse)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check level and both strobes together.
  task automatic check_out(input string tag, input logic lvl, input logic rise, input logic fall);
    check({tag, ".level"}, {7'd0, btn_level},  {7'd0, lvl});
    check({tag, ".rise"},  {7'd0, rise_pulse}, {7'd0, rise});
    check({tag, ".fall"},  {7'd0, fall_pulse}, {7'd0, fall});
  endtask

  // Full clean press and release; level is 1 after edge 6 of the press
  // and 0 again after edge 6 of the release.
  task automatic do_press();
    btn_in = 1'b1;
    repeat (8) step();
    btn_in = 1'b0;
    repeat (8) step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int rise_seen;
  int fall_seen;
  int exp_press;

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    #1;

    // Reset held with a toggling pin: everything stays zero.
    for (int i = 0; i < 8; i++) begin
      btn_in = ~btn_in;
      step();
      check_out("reset", 1'b0, 1'b0, 1'b0);
`ifdef BTN_PRESS_CNT_EN
      check("reset.press_cnt", press_cnt, 8'd0);
`endif
    end

    btn_in = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_out("idle", 1'b0, 1'b0, 1'b0);

    // Clean press: rise and level at edge 6 only.
    btn_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_out($sformatf("press.e%0d", k), (k >= 6), (k == 6), 1'b0);
    end
    repeat (3) step();
    check_out("press.hold", 1'b1, 1'b0, 1'b0);

    // Release: fall and level low at edge 6, no rise.
    btn_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_out($sformatf("release.e%0d", k), (k < 6), 1'b0, (k == 6));
    end
    repeat (3) step();

    // Bounce of 3 samples: rejected.
    btn_in = 1'b1;
    repeat (3) step();
    btn_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_out($sformatf("bounce.e%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // A 6-cycle high afterwards: exactly one rise, then one fall on release.
    rise_seen = 0;
    fall_seen = 0;
    btn_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      rise_seen += int'(rise_pulse);
      fall_seen += int'(fall_pulse);
    end
    check("long.level_hi", {7'd0, btn_level}, 8'd1);
    btn_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      rise_seen += int'(rise_pulse);
      fall_seen += int'(fall_pulse);
    end
    check("long.rise_count", 8'(rise_seen), 8'd1);
    check("long.fall_count", 8'(fall_seen), 8'd1);
    check("long.level_lo", {7'd0, btn_level}, 8'd0);

    // Reset mid-WAIT at cnt=2 (edge 4), released with the pin still high.
    btn_in = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_out("midwait.in_reset", 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_out($sformatf("midwait.e%0d", k), (k >= 6), (k == 6), 1'b0);
    end
`ifdef BTN_PRESS_CNT_EN
    check("midwait.press_cnt", press_cnt, 8'd1);
`endif
    btn_in = 1'b0;
    repeat (8) step();
    check_out("midwait.released", 1'b0, 1'b0, 1'b0);

`ifdef BTN_PRESS_CNT_EN
    // Wrap: counter reaches 255, then one more press gives 0.
    exp_press = 1;
    while (exp_press < 255) begin
      do_press();
      exp_press++;
    end
    check("wrap.at_255", press_cnt, 8'd255);
    do_press();
    check("wrap.to_0", press_cnt, 8'd0);
`else
    exp_press = 0;
    do_press();
    check_out("final", 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
